// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response and memory-side bundle for dmem_arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  Req0Valid;
  logic                  Req0Write;
  logic [ADDR_WIDTH-1:0] Req0Address;
  logic [DATA_WIDTH-1:0] Req0WriteData;
  logic                  Req0Ready;
  logic                  Req1Valid;
  logic                  Req1Write;
  logic [ADDR_WIDTH-1:0] Req1Address;
  logic [DATA_WIDTH-1:0] Req1WriteData;
  logic                  Req1Ready;
  logic                  Resp0Valid;
  logic [DATA_WIDTH-1:0] Resp0ReadData;
  logic                  Resp1Valid;
  logic [DATA_WIDTH-1:0] Resp1ReadData;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] MemWriteData;
  logic                  MemoryRead;
  logic                  MemoryWrite;
  logic [DATA_WIDTH-1:0] MemReadData;
  logic                  Busy;

  modport slave (
    input  Req0Valid, Req0Write, Req0Address, Req0WriteData,
    input  Req1Valid, Req1Write, Req1Address, Req1WriteData,
    input  MemReadData,
    output Req0Ready, Req1Ready,
    output Resp0Valid, Resp0ReadData, Resp1Valid, Resp1ReadData,
    output MemAddress, MemWriteData, MemoryRead, MemoryWrite,
    output Busy
  );

  modport master (
    output Req0Valid, Req0Write, Req0Address, Req0WriteData,
    output Req1Valid, Req1Write, Req1Address, Req1WriteData,
    output MemReadData,
    input  Req0Ready, Req1Ready,
    input  Resp0Valid, Resp0ReadData, Resp1Valid, Resp1ReadData,
    input  MemAddress, MemWriteData, MemoryRead, MemoryWrite,
    input  Busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and access sequencer for the data memory.
// Ports: Clock, Reset_n (async low), bus (slave: requests, responses, memory, Busy).
module dmem_arbiter #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input logic           Clock,
  input logic           Reset_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic                  grant_id;
  logic                  gnt1;
  logic                  idle;
  logic                  any_valid;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // On a tie the requester that did not win last time goes first,
  // unless fixed priority pins the tie to requester 0.
  always_comb begin
    gnt1 = bus.Req1Valid;
    if (bus.Req0Valid && bus.Req1Valid) begin
      gnt1 = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
    end
    sel_write = gnt1 ? bus.Req1Write     : bus.Req0Write;
    sel_addr  = gnt1 ? bus.Req1Address   : bus.Req0Address;
    sel_wdata = gnt1 ? bus.Req1WriteData : bus.Req0WriteData;
  end

  assign idle      = (state == IDLE);
  assign any_valid = bus.Req0Valid | bus.Req1Valid;
  assign bus.Req0Ready = idle & bus.Req0Valid & ~gnt1;
  assign bus.Req1Ready = idle & gnt1;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      grant_id          <= 1'b0;
      bus.MemAddress    <= '0;
      bus.MemWriteData  <= '0;
      bus.MemoryRead    <= 1'b0;
      bus.MemoryWrite   <= 1'b0;
      bus.Resp0Valid    <= 1'b0;
      bus.Resp1Valid    <= 1'b0;
      bus.Resp0ReadData <= '0;
      bus.Resp1ReadData <= '0;
      bus.Busy          <= 1'b0;
    end else begin
      bus.Resp0Valid <= 1'b0;
      bus.Resp1Valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            bus.MemAddress   <= sel_addr;
            bus.MemWriteData <= sel_wdata;
            bus.MemoryWrite  <= sel_write;
            bus.MemoryRead   <= ~sel_write;
            grant_id         <= gnt1;
            last_grant       <= gnt1;
            bus.Busy         <= 1'b1;
            state            <= ACCESS;
          end
        end
        ACCESS: begin
          bus.MemoryRead  <= 1'b0;
          bus.MemoryWrite <= 1'b0;
          // The write has committed mid-cycle; reads need one more
          // cycle for the memory's registered output.
          if (bus.MemoryWrite) begin
            bus.Resp0Valid <= ~grant_id;
            bus.Resp1Valid <= grant_id;
            bus.Busy       <= 1'b0;
            state          <= IDLE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (grant_id) begin
            bus.Resp1ReadData <= bus.MemReadData;
            bus.Resp1Valid    <= 1'b1;
          end else begin
            bus.Resp0ReadData <= bus.MemReadData;
            bus.Resp0Valid    <= 1'b1;
          end
          bus.Busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.Busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter.
// A request-level model predicts grants, strobes, busy and responses.
module tb_dmem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fp ();

  dmem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(0)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .bus(bus)
  );

  dmem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1)
  ) dut_fp (
    .Clock(Clock), .Reset_n(Reset_n), .bus(bus_fp)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic void check(string name, logic [63:0] act,
                                logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endfunction

  always @(posedge Clock) cyc++;

  // memory: writes commit on the falling edge, reads registered
  logic [DW-1:0] mem [64];
  always @(negedge Clock)
    if (bus.MemoryWrite) mem[bus.MemAddress] = bus.MemWriteData;
  always @(posedge Clock)
    if (bus.MemoryRead) bus.MemReadData <= mem[bus.MemAddress];

  // request-level reference model
  typedef struct {
    int            id;
    bit            wr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sbq[$];
  int            grants[$];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] last_rd [2];
  bit            hs_valid = 1'b0;
  bit            hs_wr;
  int            hs_e;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_wd;
  int            m_last = 1;

  always @(negedge Clock) begin : monitor
    bit            busy, mw, mr, v0, v1;
    int            w, id;
    exp_t          e;
    logic [DW-1:0] rd;
    if (!Reset_n) begin
      hs_valid   = 1'b0;
      m_last     = 1;
      sbq.delete();
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else begin
      busy = hs_valid && (cyc <= hs_e + (hs_wr ? 0 : 1));
      mw   = hs_valid && (cyc == hs_e) && hs_wr;
      mr   = hs_valid && (cyc == hs_e) && !hs_wr;
      check("busy", bus.Busy, busy);
      check("mem_write", bus.MemoryWrite, mw);
      check("mem_read", bus.MemoryRead, mr);
      check("strobe_excl", bus.MemoryRead & bus.MemoryWrite, 0);
      if (mw || mr) check("mem_addr", bus.MemAddress, hs_addr);
      if (mw) check("mem_wdata", bus.MemWriteData, hs_wd);

      if (bus.Resp0Valid || bus.Resp1Valid) begin
        check("resp_both", bus.Resp0Valid & bus.Resp1Valid, 0);
        id = bus.Resp1Valid ? 1 : 0;
        rd = id ? bus.Resp1ReadData : bus.Resp0ReadData;
        if (sbq.size() == 0) begin
          check("resp_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("resp_id", id, e.id);
          check("resp_cycle", cyc, e.due);
          if (e.wr) begin
            check("wr_ack_hold", rd, last_rd[id]);
          end else begin
            check("rd_data", rd, e.data);
            last_rd[id] = e.data;
          end
        end
      end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        check("resp_missing", cyc, e.due);
      end

      v0 = bus.Req0Valid;
      v1 = bus.Req1Valid;
      if (busy || !(v0 || v1)) begin
        check("ready0_off", bus.Req0Ready, 0);
        check("ready1_off", bus.Req1Ready, 0);
      end else begin
        if (v0 && v1) w = 1 - m_last;
        else w = v1 ? 1 : 0;
        check("ready0", bus.Req0Ready, w == 0);
        check("ready1", bus.Req1Ready, w == 1);
        grants.push_back(bus.Req1Ready ? 1 : 0);
        hs_valid = 1'b1;
        hs_e     = cyc + 1;
        hs_wr    = w ? bus.Req1Write : bus.Req0Write;
        hs_addr  = w ? bus.Req1Address : bus.Req0Address;
        hs_wd    = w ? bus.Req1WriteData : bus.Req0WriteData;
        m_last   = w;
        e.id = w;
        e.wr = hs_wr;
        if (hs_wr) begin
          e.data = '0;
          e.due  = hs_e + 1;
          ref_mem[hs_addr] = hs_wd;
        end else begin
          e.data = ref_mem[hs_addr];
          e.due  = hs_e + 2;
        end
        sbq.push_back(e);
      end
    end
  end

  task automatic issue(input int id, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    bit ok = 1'b0;
    if (id == 0) begin
      bus.Req0Write = wr;
      bus.Req0Address = a;
      bus.Req0WriteData = d;
      bus.Req0Valid = 1'b1;
    end else begin
      bus.Req1Write = wr;
      bus.Req1Address = a;
      bus.Req1WriteData = d;
      bus.Req1Valid = 1'b1;
    end
    while (n < 200) begin
      @(negedge Clock);
      if ((id == 0 && bus.Req0Ready) || (id == 1 && bus.Req1Ready)) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    check("hs_timeout", ok, 1);
    @(posedge Clock);
    #1;
    if (id == 0) bus.Req0Valid = 1'b0;
    else bus.Req1Valid = 1'b0;
  endtask

  task automatic rand_traffic(input int id, input int n);
    int r;
    repeat (n) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clock);
        #1;
      end
      r = $urandom_range(0, 9);
      issue(id, 1'($urandom_range(0, 1)), (r < 8) ? AW'(r) : AW'(63),
            $urandom);
    end
  endtask

  task automatic chk_rst(string tag);
    check({tag, "_addr"}, bus.MemAddress, 0);
    check({tag, "_wdata"}, bus.MemWriteData, 0);
    check({tag, "_mrd"}, bus.MemoryRead, 0);
    check({tag, "_mwr"}, bus.MemoryWrite, 0);
    check({tag, "_rv0"}, bus.Resp0Valid, 0);
    check({tag, "_rv1"}, bus.Resp1Valid, 0);
    check({tag, "_rd0"}, bus.Resp0ReadData, 0);
    check({tag, "_rd1"}, bus.Resp1ReadData, 0);
    check({tag, "_busy"}, bus.Busy, 0);
  endtask

  task automatic fp_test();
    int hs0 = 0;
    int n = 0;
    @(posedge Clock);
    #1;
    bus_fp.Req0Write = 1'b0;
    bus_fp.Req1Write = 1'b0;
    bus_fp.Req0Address = 6'd0;
    bus_fp.Req1Address = 6'd1;
    bus_fp.Req0Valid = 1'b1;
    bus_fp.Req1Valid = 1'b1;
    repeat (8) begin
      @(negedge Clock);
      check("fp_no_r1", bus_fp.Req1Ready, 0);
      if (bus_fp.Req0Ready) hs0++;
    end
    check("fp_r0_grants", hs0 >= 2, 1);
    while (n < 10 && !bus_fp.Req0Ready) begin
      @(negedge Clock);
      n++;
    end
    check("fp_r0_ready", bus_fp.Req0Ready, 1);
    @(posedge Clock);
    #1;
    bus_fp.Req0Valid = 1'b0;
    n = 0;
    while (n < 6) begin
      @(negedge Clock);
      n++;
      if (bus_fp.Req1Ready) break;
    end
    check("fp_r1_wait", n, 3);
    @(posedge Clock);
    #1;
    bus_fp.Req1Valid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [DW-1:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    bus.Req0Valid = 0; bus.Req0Write = 0;
    bus.Req0Address = 0; bus.Req0WriteData = 0;
    bus.Req1Valid = 0; bus.Req1Write = 0;
    bus.Req1Address = 0; bus.Req1WriteData = 0;
    bus_fp.Req0Valid = 0; bus_fp.Req0Write = 0;
    bus_fp.Req0Address = 0; bus_fp.Req0WriteData = 0;
    bus_fp.Req1Valid = 0; bus_fp.Req1Write = 0;
    bus_fp.Req1Address = 0; bus_fp.Req1WriteData = 0;
    bus_fp.MemReadData = '0;

    Reset_n = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk_rst("rst");
    #2 Reset_n = 1'b1;

    fp_test();

    issue(0, 1'b1, 6'd5, 32'hDEADBEEF);
    issue(0, 1'b0, 6'd5, '0);

    grants.delete();
    fork
      repeat (4) issue(0, 1'b0, 6'd1, '0);
      repeat (4) issue(1, 1'b0, 6'd2, '0);
    join
    check("rr_count", grants.size(), 8);
    for (int i = 1; i < grants.size(); i++)
      check("rr_alternate", grants[i] != grants[i-1], 1);

    fork
      issue(0, 1'b0, 6'd63, '0);
      issue(1, 1'b1, 6'd63, 32'h12345678);
    join
    fork
      issue(1, 1'b1, 6'd63, 32'h87654321);
      begin
        @(posedge Clock);
        #1;
        issue(0, 1'b0, 6'd63, '0);
      end
    join

    fork
      rand_traffic(0, 60);
      rand_traffic(1, 60);
    join
    repeat (5) @(posedge Clock);

    // abort a write to an address never read afterwards
    #1;
    bus.Req0Write = 1'b1;
    bus.Req0Address = 6'd40;
    bus.Req0WriteData = 32'hCAFEF00D;
    bus.Req0Valid = 1'b1;
    @(negedge Clock);
    check("abort_ready", bus.Req0Ready, 1);
    @(posedge Clock);
    #1;
    bus.Req0Valid = 1'b0;
    @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1 chk_rst("abort");
    @(posedge Clock);
    #1 chk_rst("abort_hold");
    @(negedge Clock);
    #2 Reset_n = 1'b1;
    @(posedge Clock);
    #1;
    fork
      issue(0, 1'b0, 6'd1, '0);
      issue(1, 1'b0, 6'd2, '0);
      begin
        @(negedge Clock);
        check("tie_after_rst_r0", bus.Req0Ready, 1);
        check("tie_after_rst_r1", bus.Req1Ready, 0);
      end
    join

    repeat (6) @(posedge Clock);
    @(negedge Clock);
    check("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the 64 x 32 data memory, whose writes commit on the falling clock edge and whose reads are registered on the rising edge. It sits between the memory and two masters: requester 0, the processor load/store path, and requester 1, the DMA/debug port. It accepts one request at a time through a valid/ready handshake and drives the memory control, address and data lines from registers. It returns read data, or a write acknowledge, to the granted requester as a one-cycle response pulse.

## Interface
- ADDR_WIDTH, 6: memory word-address width.
- DATA_WIDTH, 32: data word width.
- FIXED_PRIORITY, 0: 0 = round-robin arbitration; 1 = requester 0 always wins ties.

- Clock  in  1  single clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req0Valid / Req1Valid  in  1  request present.
- Req0Write / Req1Write  in  1  1 = write, 0 = read.
- Req0Address / Req1Address  in  ADDR_WIDTH  word address.
- Req0WriteData / Req1WriteData  in  DATA_WIDTH  write data.
- Req0Ready / Req1Ready  out  1  combinational accept; a handshake is Valid & Ready at a rising edge.
- Resp0Valid / Resp1Valid  out  1  registered one-cycle response pulse.
- Resp0ReadData / Resp1ReadData  out  DATA_WIDTH  registered read data; holds its last value otherwise.
- MemAddress  out  ADDR_WIDTH  registered address to memory.
- MemWriteData  out  DATA_WIDTH  registered write data to memory.
- MemoryRead  out  1  registered read strobe.
- MemoryWrite  out  1  registered write strobe.
- MemReadData  in  DATA_WIDTH  memory read data output.
- Busy  out  1  1 whenever the state is not IDLE.

## Operation
- States: IDLE, ACCESS, CAPTURE.
- **IDLE, grant selection:** computed combinationally from the Valid inputs.
  - Both requesters valid, FIXED_PRIORITY = 1: requester 0 wins.
  - Both valid, FIXED_PRIORITY = 0: the requester not equal to LastGrant wins.
  - One requester valid: that requester wins.
- **IDLE, ready:** ReqNReady = 1 only for the winner, and only in IDLE. Both Ready signals are 0 in every other state.
- **Handshake edge:**
  - Latch the winner's Address and WriteData into MemAddress and MemWriteData.
  - Set MemoryWrite = Write and MemoryRead = !Write.
  - Latch the granted ID and set LastGrant = ID.
  - Go to ACCESS.
- **LastGrant:** updates only on a handshake. Reset value is 1, so requester 0 wins the first tie.
- **ACCESS:** exactly one strobe is high for the whole cycle.
  - A write commits at the falling edge inside this cycle.
  - A read is captured by the memory at the rising edge that ends the cycle.
  - At that ending edge, both strobes clear.
  - Write: set RespIDValid = 1 and go to IDLE.
  - Read: go to CAPTURE.
- **CAPTURE:**
  - MemReadData is valid and stable, because MemoryRead = 0 makes the memory hold its output.
  - At the ending edge, latch RespIDReadData = MemReadData, set RespIDValid = 1, and go to IDLE.
- **Response pulse:** RespNValid clears on the edge after it is set.
- **No write-data echo:** a write acknowledge leaves RespNReadData unchanged.
- **Request stability:** requesters hold Valid, Write, Address and WriteData stable until Ready. The arbiter never drops an accepted request.
- **Back-to-back requests:** a requester may issue its next request in the same cycle its response pulse is high.
- **Idle requester:** a requester with Valid = 0 never alters LastGrant.

## Timing
- **Reset:** while Reset_n = 0, state = IDLE, LastGrant = 1, and every registered output is 0 (MemAddress, MemWriteData, MemoryRead, MemoryWrite, RespNValid, RespNReadData, Busy).
- **Reset mid-operation:** reset asserted during ACCESS aborts the access; a write may or may not have committed, and no response is produced. Reset deassertion takes effect at the next rising edge.
- **Latency from handshake edge E:**
  - Strobes are high in cycle E to E+1.
  - Write: response pulse in cycle E+1 to E+2, and IDLE is re-entered at E+1.
  - Read: response pulse in cycle E+2 to E+3, and IDLE is re-entered at E+2.
- **Throughput:** one write per 2 cycles, one read per 3 cycles.
- **Read-after-write:** a read accepted after a write's acknowledge returns the new data.
- **Address range:** no wrap or range check; every ADDR_WIDTH value is a valid word.

## Test plan
- **Reset values:** assert Reset_n low mid-ACCESS -> all outputs 0, Busy = 0, no response pulse; after release, a tie grants requester 0.
- **Single write then read:** req0 writes 0xDEADBEEF to address 5, then reads address 5 -> Resp0Valid at E+1 for the write; Resp0ReadData = 0xDEADBEEF with Resp0Valid at E+2 for the read.
- **Round-robin:** both requesters continuously issue reads of addresses 1 and 2 -> grants alternate 0,1,0,1; each response carries the correct word; no requester is starved.
- **FIXED_PRIORITY = 1:** both requesters continuously valid -> only requester 0 is granted while it stays valid; requester 1 is granted in the first IDLE cycle in which Req0Valid = 0.
- **Strobe exclusivity:** random mixed traffic against a scoreboard model -> MemoryRead and MemoryWrite are never both 1; each is high exactly one cycle per access; Ready is never high outside IDLE.
- **Back-to-back cross traffic:** req1 writes 0x12345678 to address 63 while req0 has a read of address 63 pending -> the read returns the old or new value strictly according to handshake order.
